// File: rtl/fetch_decode.sv
// Fetch/decode stage of the 9-bit CPU: it drives the ROM from the register-file PC, registers the
// returned word, and decodes it into register-file controls. It also sequences start/halt, stall
// and redirect bubbles, and counts retired instructions.
module fetch_decode #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             stall,
  input  logic             redirect,
  input  logic [9:0]       p,
  input  logic [8:0]       imem_data,
  output logic [9:0]       imem_addr,
  output logic             imem_en,
  output logic             valid,
  output logic [4:0]       reg_op,
  output logic [3:0]       reg_src,
  output logic [3:0]       reg_dst,
  output logic [3:0]       instr_o,
  output logic             func,
  output logic             movp,
  output logic             halted,
  output logic [CNT_W-1:0] retired
);

  typedef enum logic [1:0] {IDLE, FILL, RUN, HALTED} state_t;

  localparam logic [8:0] HALT_WORD = 9'h001;

  state_t           state_reg, state_next;
  logic [8:0]       ir_reg, ir_next;
  logic             valid_reg, valid_next;
  logic [CNT_W-1:0] retired_reg, retired_next;
  logic [1:0]       grp_idx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= IDLE;
      ir_reg      <= '0;
      valid_reg   <= 1'b0;
      retired_reg <= '0;
    end else begin
      state_reg   <= state_next;
      ir_reg      <= ir_next;
      valid_reg   <= valid_next;
      retired_reg <= retired_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    ir_next      = ir_reg;
    valid_next   = valid_reg;
    retired_next = retired_reg;
    imem_en      = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start) state_next = FILL;
      end
      FILL: begin
        imem_en    = 1'b1;
        valid_next = 1'b0;
        state_next = RUN;
      end
      RUN: begin
        imem_en = !stall;
        if (!stall) begin
          ir_next    = imem_data;
          // A redirect turns the word fetched on the old path into a bubble.
          valid_next = !redirect;
          if (valid_reg) retired_next = retired_reg + 1'b1;
          if (valid_reg && ir_reg == HALT_WORD) begin
            valid_next = 1'b0;
            state_next = HALTED;
          end
        end
      end
      HALTED: begin
        valid_next = 1'b0;
        if (start) state_next = FILL;
      end
      default: state_next = IDLE;
    endcase
  end

  assign imem_addr = p;
  assign valid     = valid_reg;
  assign halted    = (state_reg == HALTED);
  assign retired   = retired_reg;
  assign grp_idx   = ir_reg[5:4] - 2'd1;

  always_comb begin
    reg_op  = '0;
    reg_src = '0;
    reg_dst = '0;
    instr_o = '0;
    movp    = 1'b0;
    if (valid_reg) begin
      if (ir_reg[8]) begin
        reg_op  = 5'd6;
        reg_dst = ir_reg[7:4];
        reg_src = ir_reg[3:0];
        instr_o = ir_reg[3:0];
        movp    = (ir_reg[7:4] == 4'hf);
      end else if (ir_reg[7:6] != 2'b00) begin
        reg_op  = {1'b0, ir_reg[7:4]};
        reg_src = ir_reg[3:0];
        reg_dst = ir_reg[3:0];
        instr_o = ir_reg[3:0];
      end else if (ir_reg[5:4] != 2'b00) begin
        // Opcodes 1..3 expand into four sub-ops each, numbered from 16 upward.
        reg_op  = {1'b1, grp_idx, ir_reg[3:2]};
        reg_src = 4'hd;
        reg_dst = 4'hd;
        instr_o = {2'b11, ir_reg[1:0]};
      end
    end
  end

  assign func = (reg_op == 5'd23);

endmodule
